// File: rtl/clksw_sequencer_if.sv
// Control and status bundle between the clock-switch sequencer and its
// environment (speed request, config write, switch feedback and drives).
interface clksw_sequencer_if;
  logic want_hs;
  logic hsclk_selected_in;
  logic lsclk_selected_in;
  logic cfg_wr;
  logic cfg_div;
  logic cfg_delay;
  logic hsclk_sel;
  logic cpuclk_div_sel;
  logic delay_sel;
  logic on_hs;
  logic switching;
  logic cfg_pending;
  logic err;

  modport master (
    output want_hs, hsclk_selected_in, lsclk_selected_in, cfg_wr, cfg_div, cfg_delay,
    input  hsclk_sel, cpuclk_div_sel, delay_sel, on_hs, switching, cfg_pending, err
  );

  modport slave (
    input  want_hs, hsclk_selected_in, lsclk_selected_in, cfg_wr, cfg_div, cfg_delay,
    output hsclk_sel, cpuclk_div_sel, delay_sel, on_hs, switching, cfg_pending, err
  );
endinterface

// File: rtl/clksw_sequencer.sv
// HS/LS CPU clock switch sequencer: acknowledged four-state switch with dwell,
// timeout recovery to LS and LS-only config apply. CLKSW_SYNC3_EN selects 3-FF ack synchronizers.
module clksw_sequencer #(
  parameter int unsigned DWELL_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic        DELAY_SEL_RST  = 1'b1
) (
  input logic              hsclk_in,
  input logic              rst_b,
  clksw_sequencer_if.slave bus
);

`ifdef CLKSW_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam int             TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     DWELL_LOAD = 8'(DWELL_CYCLES);

  typedef enum logic [1:0] {ST_LS, ST_SW_HS, ST_HS, ST_SW_LS} state_t;

  logic [SYNC_STAGES-1:0] hs_sync, ls_sync;
  logic                   hs_s, ls_s, hs_ack, ls_ack;

  state_t        state;
  logic [7:0]    dwell_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          pend_div, pend_delay;
  logic          hsclk_sel_q, div_sel_q, delay_sel_q;
  logic          on_hs_q, switching_q, cfg_pending_q, err_q;
  logic          dwell_done, tmo_hit;

  // NOTE: synchronizer flops reset to the settled-LS pattern (hs=0, ls=1),
  // so the chain never presents a false acknowledge coming out of reset.
  always_ff @(posedge hsclk_in) begin
    if (!rst_b) begin
      hs_sync <= '0;
      ls_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], bus.hsclk_selected_in};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], bus.lsclk_selected_in};
    end
  end

  assign hs_s   = hs_sync[SYNC_STAGES-1];
  assign ls_s   = ls_sync[SYNC_STAGES-1];
  // Both-high or both-low feedback is a switch in transit, never an ack.
  assign hs_ack = hs_s & ~ls_s;
  assign ls_ack = ls_s & ~hs_s;

  assign dwell_done = (dwell_cnt == 8'd0);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  // NOTE: all state here uses non-blocking assignments; the later write to
  // cfg_pending in the same block intentionally overrides the apply-clear.
  always_ff @(posedge hsclk_in) begin
    if (!rst_b) begin
      state         <= ST_LS;
      dwell_cnt     <= DWELL_LOAD;
      tmo_cnt       <= '0;
      pend_div      <= 1'b0;
      pend_delay    <= DELAY_SEL_RST;
      hsclk_sel_q   <= 1'b0;
      div_sel_q     <= 1'b0;
      delay_sel_q   <= DELAY_SEL_RST;
      on_hs_q       <= 1'b0;
      switching_q   <= 1'b0;
      cfg_pending_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (bus.cfg_wr) begin
        pend_div   <= bus.cfg_div;
        pend_delay <= bus.cfg_delay;
      end

      unique case (state)
        ST_LS: begin
          if (!dwell_done) dwell_cnt <= dwell_cnt - 8'd1;
          if (bus.want_hs && dwell_done && !cfg_pending_q) begin
            state       <= ST_SW_HS;
            hsclk_sel_q <= 1'b1;
            switching_q <= 1'b1;
            tmo_cnt     <= '0;
          end else if (cfg_pending_q) begin
            div_sel_q     <= pend_div;
            delay_sel_q   <= pend_delay;
            cfg_pending_q <= 1'b0;
          end
        end

        ST_SW_HS: begin
          if (hs_ack) begin
            state       <= ST_HS;
            on_hs_q     <= 1'b1;
            switching_q <= 1'b0;
            dwell_cnt   <= DWELL_LOAD;
          end else if (tmo_hit) begin
            state       <= ST_SW_LS;
            hsclk_sel_q <= 1'b0;
            err_q       <= 1'b1;
            tmo_cnt     <= '0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_HS: begin
          if (!dwell_done) dwell_cnt <= dwell_cnt - 8'd1;
          // A pending config also forces a trip through LS, even if HS is still wanted.
          if (dwell_done && (!bus.want_hs || cfg_pending_q)) begin
            state       <= ST_SW_LS;
            hsclk_sel_q <= 1'b0;
            on_hs_q     <= 1'b0;
            switching_q <= 1'b1;
            tmo_cnt     <= '0;
          end
        end

        ST_SW_LS: begin
          if (ls_ack) begin
            state       <= ST_LS;
            switching_q <= 1'b0;
            dwell_cnt   <= DWELL_LOAD;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            tmo_cnt <= '0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= ST_LS;
      endcase

      if (bus.cfg_wr) cfg_pending_q <= 1'b1;
    end
  end

  assign bus.hsclk_sel      = hsclk_sel_q;
  assign bus.cpuclk_div_sel = div_sel_q;
  assign bus.delay_sel      = delay_sel_q;
  assign bus.on_hs          = on_hs_q;
  assign bus.switching      = switching_q;
  assign bus.cfg_pending    = cfg_pending_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_clksw_sequencer.sv
// Directed bench for clksw_sequencer: a table of timed steps against a
// behavioural clock-switch model that acknowledges 5 cycles after hsclk_sel changes.
module tb_clksw_sequencer;

`ifdef CLKSW_SYNC3_EN
  localparam int S = 3;
`else
  localparam int S = 2;
`endif
  localparam int ACK_DLY = 5;

  logic hsclk_in = 1'b0;
  logic rst_b    = 1'b0;

  clksw_sequencer_if bus ();

  clksw_sequencer dut (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .bus      (bus)
  );

  always #5 hsclk_in = ~hsclk_in;

  typedef struct {
    logic       rst;
    logic       want;
    logic       wr;
    logic       div;
    logic       dly;
    logic       men;
    int         ncyc;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic model_en = 1'b1;
  logic m_sel    = 1'b0;
  int   m_cnt    = ACK_DLY;

  function automatic void add(logic r, logic w, logic wr, logic d, logic dl, logic men,
                              int n, logic [6:0] e, string nm);
    vec_t v;
    v = '{r, w, wr, d, dl, men, n, e, nm};
    vecs.push_back(v);
  endfunction

  // {hsclk_sel, on_hs, switching, cfg_pending, cpuclk_div_sel, delay_sel, err}
  function automatic logic [6:0] outs();
    return {bus.hsclk_sel, bus.on_hs, bus.switching, bus.cfg_pending,
            bus.cpuclk_div_sel, bus.delay_sel, bus.err};
  endfunction

  task automatic check(string name, logic [6:0] got, logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b expected %b (hs_sel,on_hs,sw,pend,div,dly,err)", name, got, exp);
    end
  endtask

  // One clock; the switch model then reacts #1 after the edge.
  task automatic step();
    @(posedge hsclk_in);
    #1;
    if (!model_en) begin
      bus.hsclk_selected_in = 1'b0;
      bus.lsclk_selected_in = 1'b0;
      m_sel = bus.hsclk_sel;
      m_cnt = 0;
    end else if (bus.hsclk_sel != m_sel) begin
      m_sel = bus.hsclk_sel;
      m_cnt = 0;
      bus.hsclk_selected_in = 1'b0;
      bus.lsclk_selected_in = 1'b0;
    end else if (m_cnt < ACK_DLY) begin
      m_cnt++;
      if (m_cnt == ACK_DLY) begin
        bus.hsclk_selected_in = m_sel;
        bus.lsclk_selected_in = ~m_sel;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    bus.want_hs           = 1'b0;
    bus.hsclk_selected_in = 1'b0;
    bus.lsclk_selected_in = 1'b1;
    bus.cfg_wr            = 1'b0;
    bus.cfg_div           = 1'b0;
    bus.cfg_delay         = 1'b0;

    //  rst want wr div dly men  ncyc        expected   name
    add(0, 0, 0, 0, 0, 1, 2,           7'b0000010, "reset_state");
    add(1, 1, 0, 0, 0, 1, 8,           7'b0000010, "dwell_hold");
    add(1, 1, 0, 0, 0, 1, 1,           7'b1010010, "sw_hs_start");
    add(1, 1, 0, 0, 0, 1, ACK_DLY + S, 7'b1010010, "sw_hs_wait");
    add(1, 1, 0, 0, 0, 1, 1,           7'b1100010, "on_hs_rise");
    add(1, 1, 0, 0, 0, 1, 2,           7'b1100010, "hs_settled");
    add(1, 0, 0, 0, 0, 1, 6,           7'b1100010, "hs_dwell_hold");
    add(1, 0, 0, 0, 0, 1, 1,           7'b0010010, "sw_ls_start");
    add(1, 0, 0, 0, 0, 1, ACK_DLY + S, 7'b0010010, "sw_ls_wait");
    add(1, 0, 0, 0, 0, 1, 1,           7'b0000010, "ls_reached");
    add(1, 1, 0, 0, 0, 0, 9,           7'b1010010, "tmo_sw_hs");
    add(1, 1, 0, 0, 0, 0, 63,          7'b1010010, "tmo_last_wait");
    add(1, 1, 0, 0, 0, 0, 1,           7'b0010011, "tmo_hit");
    add(1, 1, 0, 0, 0, 0, 70,          7'b0010011, "tmo_sw_ls_stuck");
    add(1, 1, 0, 0, 0, 1, ACK_DLY + S, 7'b0010011, "tmo_ls_wait");
    add(1, 1, 0, 0, 0, 1, 1,           7'b0000011, "tmo_ls_err_sticky");
    add(1, 1, 0, 0, 0, 1, 15 + S,      7'b1100011, "cfg_hs_entry");
    add(1, 1, 1, 0, 1, 1, 1,           7'b1101011, "cfg_wr_in_hs");
    add(1, 1, 1, 1, 0, 1, 1,           7'b1101011, "cfg_overwrite");
    add(1, 1, 0, 0, 0, 1, 7,           7'b0011011, "cfg_forces_sw_ls");
    add(1, 1, 0, 0, 0, 1, ACK_DLY+S+1, 7'b0001011, "cfg_ls_pending");
    add(1, 1, 0, 0, 0, 1, 1,           7'b0000101, "cfg_applied");
    add(1, 1, 0, 0, 0, 1, 8,           7'b1010101, "cfg_return_sw_hs");
    add(1, 1, 0, 0, 0, 1, ACK_DLY+S+1, 7'b1100101, "cfg_return_hs");
    add(1, 0, 0, 0, 0, 1, 9,           7'b0010101, "pre_rst_sw_ls");
    add(1, 0, 0, 0, 0, 1, ACK_DLY+S+1, 7'b0000101, "pre_rst_ls");
    add(1, 1, 0, 0, 0, 1, 9,           7'b1010101, "pre_rst_sw_hs");
    add(0, 1, 0, 0, 0, 1, 1,           7'b0000010, "rst_mid_switch");

    foreach (vecs[i]) begin
      rst_b         = vecs[i].rst;
      bus.want_hs   = vecs[i].want;
      bus.cfg_wr    = vecs[i].wr;
      bus.cfg_div   = vecs[i].div;
      bus.cfg_delay = vecs[i].dly;
      model_en      = vecs[i].men;
      for (int k = 0; k < vecs[i].ncyc; k++) begin
        step();
        bus.cfg_wr = 1'b0;
      end
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Back-to-back writes in LS: the write landing on the apply cycle must survive.
    rst_b         = 1'b1;
    bus.want_hs   = 1'b0;
    bus.cfg_wr    = 1'b1;
    bus.cfg_div   = 1'b1;
    bus.cfg_delay = 1'b1;
    step();
    check("ls_wr_capture", outs(), 7'b0001010);
    bus.cfg_div   = 1'b0;
    bus.cfg_delay = 1'b0;
    step();
    check("ls_wr_on_apply", outs(), 7'b0001110);
    bus.cfg_wr = 1'b0;
    step();
    check("ls_second_apply", outs(), 7'b0000000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clksw_sequencer.md
Name: clksw_sequencer

Overview:
- Sequencer that drives the HS/LS CPU clock switch's `hsclk_sel`, `cpuclk_div_sel` and `delay_sel` controls.
- Runs entirely in the `hsclk_in` domain.
- Converts a level speed request from the address decoder into a four-state, fully acknowledged switch sequence, using the switch's `hsclk_selected` and `lsclk_selected` feedback.
- Enforces a minimum dwell time, applies a timeout with recovery to LS, and only changes divider/delay configuration while LS is settled.

Parameters:
- DWELL_CYCLES, 8: minimum `hsclk_in` cycles spent in a settled state before another switch may start. Range 1..255.
- TIMEOUT_CYCLES, 64: maximum `hsclk_in` cycles to wait for switch acknowledge. Range 2..1023.
- DELAY_SEL_RST, 1: reset value of `delay_sel`.

Ports:
- hsclk_in  in  1  sole clock, rising edge.
- rst_b  in  1  synchronous active-low reset, sampled on posedge `hsclk_in`.
- want_hs  in  1  level request: 1 = run CPU on HS clock, 0 = LS.
- hsclk_selected_in  in  1  asynchronous feedback from the clock switch.
- lsclk_selected_in  in  1  asynchronous feedback from the clock switch.
- cfg_wr  in  1  single-cycle strobe; captures `cfg_div` and `cfg_delay`.
- cfg_div  in  1  requested `cpuclk_div_sel`.
- cfg_delay  in  1  requested `delay_sel`.
- hsclk_sel  out  1  to clock switch.
- cpuclk_div_sel  out  1  to clock switch.
- delay_sel  out  1  to clock switch.
- on_hs  out  1  1 only in state HS.
- switching  out  1  1 in states SW_HS and SW_LS.
- cfg_pending  out  1  a captured configuration is not yet applied.
- err  out  1  sticky timeout flag.

Behaviour:
- Synchronizers:
  - `hsclk_selected_in` and `lsclk_selected_in` each pass through a 2-FF synchronizer, giving `hs_s` and `ls_s`.
  - Synchronizer flops reset to `hs_s`=0, `ls_s`=1.
- Reset (`rst_b`=0 at a posedge): all outputs are registered and take these values at that edge.
  - state = LS, `hsclk_sel`=0, `cpuclk_div_sel`=0, `delay_sel`=DELAY_SEL_RST.
  - `cfg_pending`=0, `err`=0, dwell counter = DWELL_CYCLES, timeout counter = 0.
  - A reset in the middle of a switch abandons it; `hsclk_sel` is 0 one edge later.
- Dwell counter:
  - Loaded with DWELL_CYCLES on entry to LS or HS.
  - Decrements each cycle in LS or HS while nonzero.
  - "dwell done" = counter is 0.
- State LS (`hsclk_sel`=0):
  - If `want_hs`=1, dwell done and `cfg_pending`=0: go to SW_HS, `hsclk_sel`=1 on the same edge, timeout counter cleared.
  - Otherwise, if `cfg_pending`=1: apply `cpuclk_div_sel`/`delay_sel` from the pending registers and clear `cfg_pending`. This takes one cycle and blocks the switch for that cycle.
- State SW_HS (`hsclk_sel`=1):
  - If `hs_s`=1 and `ls_s`=0: go to HS.
  - Else if the timeout counter reaches TIMEOUT_CYCLES-1: set `err`, drop `hsclk_sel` to 0, go to SW_LS.
  - Otherwise increment the timeout counter.
- State HS (`hsclk_sel`=1):
  - If `want_hs`=0 and dwell done: go to SW_LS, `hsclk_sel`=0, timeout counter cleared.
  - If `cfg_pending`=1 and dwell done: also go to SW_LS, even when `want_hs`=1. The config is applied in LS, and the block then returns to HS.
- State SW_LS (`hsclk_sel`=0):
  - If `ls_s`=1 and `hs_s`=0: go to LS.
  - On timeout: set `err`, stay in SW_LS with `hsclk_sel`=0 and restart the timeout count. There is never a retry to HS without LS acknowledge.
- Request changes mid-switch:
  - A `want_hs` change during SW_HS/SW_LS is ignored until the settled state is reached.
  - The request is then re-evaluated after dwell.
- Config capture:
  - `cfg_wr`=1 latches `cfg_div`/`cfg_delay` into the pending registers and sets `cfg_pending`.
  - A second `cfg_wr` before apply overwrites the pending values (last write wins).
  - A `cfg_wr` on the same cycle as apply re-sets `cfg_pending` with the new values, so that write is not lost.
- Contradictory acknowledge: `hs_s`=`ls_s`=1 or `hs_s`=`ls_s`=0 is never treated as acknowledge.
- `err` clears only by reset.
- Timeout counter width is ceil(log2(TIMEOUT_CYCLES)) bits, saturating.
- Latency, from the edge that samples the request to `on_hs`=1: 1 cycle for `hsclk_sel` + switch latency + 2 synchronizer cycles + 1 cycle.

Optional Feature:
- Macro CLKSW_SYNC3_EN.
- When defined: both feedback synchronizers are 3-FF. Acknowledge latency increases by exactly 1 cycle. Timeout counting is unchanged.
- When undefined: 2-FF synchronizers as described in Behaviour.

Test Plan:
- Reset, then `want_hs`=1 held; switch model acks `hs`=1/`ls`=0 after 5 cycles -> `hsclk_sel`=1 from cycle 8 (dwell of 8 after reset). `switching`=1 until the ack reaches `hs_s` after 2 synchronizer stages, then `on_hs`=1 one cycle later; `err`=0.
- In HS, drop `want_hs` to 0 after 2 cycles -> `hsclk_sel` stays 1 until dwell expires (8 cycles after HS entry), then 0. `on_hs` falls the same edge; LS is reached after the ls ack.
- In SW_HS, model never acks -> after 64 cycles `err`=1, `hsclk_sel`=0, state SW_LS. Model then acks LS -> state LS; `err` stays 1.
- In HS, `cfg_wr` with `cfg_div`=1, `cfg_delay`=0 and `want_hs`=1 -> the block goes to LS, applies `cpuclk_div_sel`=1 and `delay_sel`=0 while `hsclk_sel`=0, clears `cfg_pending`, then returns to HS after dwell.
- `rst_b`=0 for 1 cycle during SW_HS -> next edge `hsclk_sel`=0, `switching`=0, `cpuclk_div_sel`=0, `delay_sel`=1, `err`=0.
- With CLKSW_SYNC3_EN defined, repeat the first scenario -> `on_hs` rises exactly 1 cycle later than without the macro.
